// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and the response record.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      slverr;
  } apb_resp_t;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Storage for the APB memory: synchronous write, registered read with enable.
// Left without reset so that it maps onto block RAM.
module apb_slave_mem_array #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // The read register only updates on a read hit, so it holds the last read value.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer in front of a byte memory: parameterised wait states,
// PSLVERR for addresses beyond MEM_DEPTH, all outputs registered.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                  IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [3:0]          WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic                ZERO_WAIT = (WAIT_CYCLES == 0);

  apb_state_e            r_state, w_stateNext;
  logic [3:0]            r_cnt, w_cntNext;
  logic                  r_ready, w_readyNext;
  logic                  r_slverr, w_slverrNext;
  logic                  r_err, w_errNext;
  logic                  r_write, w_writeNext;
  logic                  r_rdZero, w_rdZeroNext;
  logic [IDX_W-1:0]      r_idx, w_idxNext;
  logic [IDX_W-1:0]      w_rdIdx;
  logic                  w_memWe, w_memRe;
  logic                  w_setupErr;
  logic [DATA_WIDTH-1:0] w_memQ;

  assign w_setupErr = ({1'b0, PADDR} >= DEPTH_LIM);

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_readyNext  = r_ready;
    w_slverrNext = r_slverr;
    w_errNext    = r_err;
    w_writeNext  = r_write;
    w_rdZeroNext = r_rdZero;
    w_idxNext    = r_idx;
    w_rdIdx      = r_idx;
    w_memWe      = 1'b0;
    w_memRe      = 1'b0;
    case (r_state)
      IDLE: begin
        w_readyNext  = 1'b0;
        w_slverrNext = 1'b0;
        // A zero-wait read must fetch on the setup edge, before the address is latched.
        w_rdIdx      = PADDR[IDX_W-1:0];
        if (PSEL && !PENABLE) begin
          w_stateNext  = ACCESS;
          w_cntNext    = WAIT_LD;
          w_errNext    = w_setupErr;
          w_writeNext  = PWRITE;
          w_idxNext    = PADDR[IDX_W-1:0];
          w_readyNext  = ZERO_WAIT;
          w_slverrNext = ZERO_WAIT && w_setupErr;
          if (ZERO_WAIT && !PWRITE) begin
            w_rdZeroNext = w_setupErr;
            w_memRe      = !w_setupErr;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          w_stateNext  = IDLE;
          w_cntNext    = 4'd0;
          w_readyNext  = 1'b0;
          w_slverrNext = 1'b0;
        end else if (r_cnt != 4'd0) begin
          w_cntNext = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_readyNext  = 1'b1;
            w_slverrNext = r_err;
            if (!r_write) begin
              w_rdZeroNext = r_err;
              w_memRe      = !r_err;
            end
          end
        end else if (r_ready && PENABLE) begin
          w_memWe      = r_write && !r_err;
          w_stateNext  = IDLE;
          w_readyNext  = 1'b0;
          w_slverrNext = 1'b0;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_err    <= 1'b0;
      r_write  <= 1'b0;
      r_rdZero <= 1'b1;
      r_idx    <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_ready  <= w_readyNext;
      r_slverr <= w_slverrNext;
      r_err    <= w_errNext;
      r_write  <= w_writeNext;
      r_rdZero <= w_rdZeroNext;
      r_idx    <= w_idxNext;
    end
  end

  // Reset must also block a write or read that completes on the same edge.
  apb_slave_mem_array #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .i_clk   (PCLK),
    .i_we    (w_memWe && !PRESET),
    .i_waddr (r_idx),
    .i_wdata (PWDATA),
    .i_re    (w_memRe && !PRESET),
    .i_raddr (w_rdIdx),
    .o_rdata (w_memQ)
  );

  assign PREADY  = r_ready;
  assign PSLVERR = r_slverr;
  assign PRDATA  = r_rdZero ? '0 : w_memQ;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a two-wait-state instance (A) and a
// zero-wait instance (B) share the bus and differ only in PSEL.
module tb_apb_slave_mem;
  import apb_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] paddr;
  logic [7:0]  pwdata;
  logic        penable;
  logic        pwrite;
  logic        pselA, pselB;
  logic [7:0]  prdataA, prdataB;
  logic        preadyA, preadyB;
  logic        pslverrA, pslverrB;

  int checkCount = 0;
  int passCount  = 0;

  apb_slave_mem #(.WAIT_CYCLES(2)) dutA (
    .PCLK(clock), .PRESET(reset), .PADDR(paddr), .PWDATA(pwdata),
    .PSEL(pselA), .PENABLE(penable), .PWRITE(pwrite),
    .PRDATA(prdataA), .PREADY(preadyA), .PSLVERR(pslverrA)
  );

  apb_slave_mem #(.WAIT_CYCLES(0)) dutB (
    .PCLK(clock), .PRESET(reset), .PADDR(paddr), .PWDATA(pwdata),
    .PSEL(pselB), .PENABLE(penable), .PWRITE(pwrite),
    .PRDATA(prdataB), .PREADY(preadyB), .PSLVERR(pslverrB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        zeroWait;
    logic        isWrite;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  expRdata;
    logic        expErr;
  } vector_t;

  vector_t vecs[20];

  function automatic logic readyOf(input logic zeroWait);
    return zeroWait ? preadyB : preadyA;
  endfunction

  function automatic apb_resp_t respOf(input logic zeroWait);
    apb_resp_t r;
    r.rdata  = zeroWait ? prdataB : prdataA;
    r.slverr = zeroWait ? pslverrB : pslverrA;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // One complete transfer; returns the response seen while PREADY=1, the
  // number of PREADY-low access cycles, and PREADY|PSLVERR after completion.
  task automatic applyStimulus(input logic zeroWait, input logic isWrite, input logic [15:0] addr,
                               input logic [7:0] data, output apb_resp_t resp, output int waits,
                               output logic postBusy);
    paddr   = addr;
    pwrite  = isWrite;
    pwdata  = data;
    penable = 1'b0;
    if (zeroWait) pselB = 1'b1;
    else pselA = 1'b1;
    @(posedge clock); #1;
    penable = 1'b1;
    waits   = 0;
    while (!readyOf(zeroWait) && waits < 40) begin
      @(posedge clock); #1;
      waits++;
    end
    resp = respOf(zeroWait);
    @(posedge clock); #1;
    postBusy = readyOf(zeroWait) | respOf(zeroWait).slverr;
    pselA   = 1'b0;
    pselB   = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    apb_resp_t resp;
    int        waits;
    logic      postBusy;

    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 8'hA5, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h00FF, 8'h3C, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0000, 8'h5A, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0100, 8'h77, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0100, 8'h00, 8'h00, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h5A, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0001, 8'h11, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'h0002, 8'h22, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h0003, 8'h33, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 16'h0004, 8'h44, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'h0001, 8'h00, 8'h11, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 16'h0002, 8'h00, 8'h22, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 16'h0003, 8'h00, 8'h33, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 16'h0004, 8'h00, 8'h44, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 16'h0020, 8'h66, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 16'h0030, 8'hC3, 8'h00, 1'b0};

    reset = 1'b1; paddr = '0; pwdata = '0; penable = 1'b0; pwrite = 1'b0;
    pselA = 1'b0; pselB = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_preadyA",  32'(preadyA),  32'h0);
    checkOutput("reset_pslverrA", 32'(pslverrA), 32'h0);
    checkOutput("reset_prdataA",  32'(prdataA),  32'h0);
    checkOutput("reset_preadyB",  32'(preadyB),  32'h0);
    checkOutput("reset_prdataB",  32'(prdataB),  32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Table-driven transfers, issued back to back
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].zeroWait, vecs[i].isWrite, vecs[i].addr, vecs[i].wdata, resp, waits, postBusy);
      checkOutput($sformatf("vec%0d_waits", i), 32'(waits), vecs[i].zeroWait ? 32'd0 : 32'd2);
      checkOutput($sformatf("vec%0d_slverr", i), 32'(resp.slverr), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d_post", i), 32'(postBusy), 32'h0);
      if (!vecs[i].isWrite)
        checkOutput($sformatf("vec%0d_rdata", i), 32'(resp.rdata), 32'(vecs[i].expRdata));
    end

    // PENABLE without a setup phase must be ignored
    pselA = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0010;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("noSetup_ready%0d", c), 32'(preadyA), 32'h0);
    end
    pselA = 1'b0; penable = 1'b0;
    @(posedge clock); #1;

    // Abort a write after one access cycle
    pselA = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0020; pwdata = 8'h99;
    @(posedge clock); #1;
    penable = 1'b1;
    @(posedge clock); #1;
    checkOutput("abort_readyBeforeDrop", 32'(preadyA), 32'h0);
    pselA = 1'b0; penable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("abort_ready%0d", c), 32'(preadyA), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 16'h0020, 8'h00, resp, waits, postBusy);
    checkOutput("abort_rdata", 32'(resp.rdata), 32'h66);

    // Address changed during ACCESS: the setup address still selects the data
    pselA = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0010;
    @(posedge clock); #1;
    penable = 1'b1; paddr = 16'h0300;
    waits = 0;
    while (!preadyA && waits < 40) begin
      @(posedge clock); #1;
      waits++;
    end
    checkOutput("addrChange_waits",  32'(waits),    32'd2);
    checkOutput("addrChange_rdata",  32'(prdataA),  32'hA5);
    checkOutput("addrChange_slverr", 32'(pslverrA), 32'h0);
    @(posedge clock); #1;
    pselA = 1'b0; penable = 1'b0;
    @(posedge clock); #1;

    // Reset on the edge that would complete a write
    pselA = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0030; pwdata = 8'hEE;
    @(posedge clock); #1;
    penable = 1'b1;
    waits = 0;
    while (!preadyA && waits < 40) begin
      @(posedge clock); #1;
      waits++;
    end
    checkOutput("rstMid_readyBefore", 32'(preadyA), 32'h1);
    reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("rstMid_ready",  32'(preadyA),  32'h0);
    checkOutput("rstMid_slverr", 32'(pslverrA), 32'h0);
    checkOutput("rstMid_rdata",  32'(prdataA),  32'h0);
    reset = 1'b0; pselA = 1'b0; penable = 1'b0;
    @(posedge clock); #1;
    applyStimulus(1'b0, 1'b0, 16'h0030, 8'h00, resp, waits, postBusy);
    checkOutput("rstMid_memKept", 32'(resp.rdata), 32'hC3);
    checkOutput("rstMid_waits",   32'(waits),      32'd2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (slave) directly downstream of the APB bus interface; consumes PADDR/PWDATA/PSEL/PENABLE/PWRITE and produces PRDATA/PREADY/PSLVERR.
- Implements a byte-wide register memory with a parameterised number of wait states.
- Flags PSLVERR for addresses outside the implemented memory.
- Serves as the DUT the bus driver and monitor talk to.

Parameters:
- ADDR_WIDTH, 16, PADDR width.
- DATA_WIDTH, 8, PWDATA/PRDATA width.
- MEM_DEPTH, 256, number of implemented locations; valid addresses are 0 to MEM_DEPTH-1.
- WAIT_CYCLES, 2, PREADY-low cycles inserted in each access phase; range 0 to 15.

Ports:
- PCLK, input, 1, bus clock; all logic on rising edge.
- PRESET, input, 1, synchronous active-high reset.
- PADDR, input, ADDR_WIDTH, transfer address.
- PWDATA, input, DATA_WIDTH, write data.
- PSEL, input, 1, completer select.
- PENABLE, input, 1, access-phase marker.
- PWRITE, input, 1, 1 = write, 0 = read.
- PRDATA, output, DATA_WIDTH, read data; valid when PREADY=1 on a read.
- PREADY, output, 1, transfer-complete handshake.
- PSLVERR, output, 1, error response; meaningful only while PREADY=1.

Behaviour:
- Interface: one clock, PCLK. PRESET is synchronous and active-high.
- Reset: when PRESET=1 at a PCLK edge, the state goes to IDLE and the wait counter to 0. PREADY=0, PSLVERR=0, PRDATA=0. Memory contents are not cleared.
- Outputs are all registered.
- FSM states: IDLE and ACCESS.
  - IDLE: on an edge sampling PSEL=1 and PENABLE=0 (setup phase):
    - go to ACCESS and load cnt=WAIT_CYCLES;
    - latch addr_err = (PADDR >= MEM_DEPTH);
    - PREADY <= (WAIT_CYCLES==0).
  - ACCESS, cnt>0: cnt decrements; PREADY <= (cnt==1). PREADY therefore rises after exactly WAIT_CYCLES access cycles.
  - ACCESS, edge sampling PSEL=1, PENABLE=1, PREADY=1: transfer completes.
    - Write with no error: mem[PADDR] <= PWDATA.
    - PREADY<=0, PSLVERR<=0, return to IDLE.
    - The next transfer must present a new setup phase, so back-to-back transfers cost a minimum of 2 cycles each.
- Read data and error timing:
  - Read data is loaded into PRDATA on the same edge that sets PREADY=1: mem[PADDR] if the address is valid, 0x00 on error.
  - PRDATA holds its last value otherwise.
  - PSLVERR <= addr_err on the edge that sets PREADY=1; it is 0 at all other times.
- Errored write: memory is unchanged and PSLVERR=1 with PREADY.
- Errored read: PRDATA=0x00 and PSLVERR=1.
- Protocol violations:
  - PSEL falls while in ACCESS (abort): return to IDLE, PREADY=0, PSLVERR=0, no memory write.
  - PENABLE=1 seen in IDLE without a prior setup phase: ignored, stay in IDLE.
  - PADDR/PWRITE/PWDATA changing during ACCESS: the address used for the error check and read is the value latched at setup. Write data is sampled at the completion edge.
- Simultaneous events: PRESET wins over everything, including a completing write. A write completing with reset asserted does not update memory.
- Address arithmetic: comparison against MEM_DEPTH is unsigned and full-width. The memory index is PADDR[$clog2(MEM_DEPTH)-1:0] and is used only when there is no error.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum (IDLE, ACCESS);
  - APB_ADDR_WIDTH=16 and APB_DATA_WIDTH=8 localparams;
  - an apb_resp_t struct {rdata, slverr}.
- One sub-module, apb_slave_mem_array: MEM_DEPTH x DATA_WIDTH synchronous-write, registered-read storage. It has no reset so that it infers as RAM.
- FSM, wait counter and error logic stay in apb_slave_mem.

Test Plan:
- Write/read, WAIT_CYCLES=2: write 0xA5 to 0x0010, then read 0x0010 -> PREADY low for exactly 2 access cycles then high 1 cycle; PRDATA=0xA5; PSLVERR=0.
- Zero-wait build (WAIT_CYCLES=0): write 0x3C to 0x00FF, read back -> PREADY high in the first access cycle; PRDATA=0x3C.
- Out-of-range: write 0x77 to 0x0100, then read 0x0100 -> PSLVERR=1 with PREADY on both transfers; PRDATA=0x00; mem[0x00] unchanged.
- Back-to-back writes to 0x0001..0x0004 (0x11..0x44), then reads -> each transfer takes 2+WAIT_CYCLES cycles; read data matches.
- Abort: setup a write to 0x0020 with data 0x99, drop PSEL after 1 access cycle -> PREADY stays 0; a later read of 0x0020 returns the prior value.
- Reset mid-access: assert PRESET during ACCESS of a write to 0x0030 -> next edge gives PREADY=0, PSLVERR=0, PRDATA=0, state IDLE; mem[0x30] not written.
